// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer: assembles PS/2 scan-code sequences into key/control events; PS2_RX_TIMEOUT_EN enables prefix timeout
module ps2_rx_sequencer #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int TO_W = 20,
  parameter logic [7:0] JUMP_CODE = 8'h29,
  parameter logic [7:0] DUCK_CODE = 8'h72
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tx_busy,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       wait_for_incoming_data,
  output logic       start_receiving_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic [7:0] ctrl_byte,
  output logic       ctrl_valid,
  output logic       jump_held,
  output logic       duck_held,
  output logic       seq_error
);
  localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, EXT = 3'd2, BRK = 3'd3, EXT_BRK = 3'd4;
  logic [2:0] state, nxt;
  logic run, is_ctrl, to_hit, ev_key, ev_ext, ev_brk, ev_ctrl, ev_err;
  logic [7:0] d;
  assign d = received_data;
  assign run = enable && !tx_busy;
  assign is_ctrl = d inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
  assign start_receiving_data = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic prefix;
  assign prefix = state inside {EXT, BRK, EXT_BRK};
  assign to_hit = prefix && !received_data_en && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || !run || received_data_en || !prefix) to_cnt <= '0;
    else if (to_cnt != {TO_W{1'b1}}) to_cnt <= to_cnt + 1'b1;
`else
  logic [TO_W-1:0] unused_timeout;
  assign unused_timeout = TO_W'(TIMEOUT_CYCLES);
  assign to_hit = 1'b0;
`endif
  always_comb begin
    nxt = state;
    ev_key = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    ev_ctrl = 1'b0;
    ev_err = 1'b0;
    if (!run) nxt = IDLE;
    else if (state == IDLE) nxt = ARMED;
    else if (received_data_en) begin
      if (state == ARMED) begin
        if (d == 8'hE0) nxt = EXT;
        else if (d == 8'hF0) nxt = BRK;
        else if (is_ctrl) ev_ctrl = 1'b1;
        else if (d == 8'hE1) ev_err = 1'b1;
        else ev_key = 1'b1;
      end else if (state == EXT) begin
        nxt = d == 8'hF0 ? EXT_BRK : d == 8'hE0 ? EXT : ARMED;
        ev_err = is_ctrl;
        ev_key = !is_ctrl && d != 8'hF0 && d != 8'hE0;
        ev_ext = 1'b1;
      end else begin
        nxt = ARMED;
        ev_err = is_ctrl || d == 8'hE0 || d == 8'hF0;
        ev_key = !ev_err;
        ev_ext = state == EXT_BRK;
        ev_brk = 1'b1;
      end
    end else if (to_hit) begin
      nxt = ARMED;
      ev_err = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_for_incoming_data <= 1'b0;
      key_code <= '0;
      key_ext <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      ctrl_byte <= '0;
      ctrl_valid <= 1'b0;
      jump_held <= 1'b0;
      duck_held <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      state <= nxt;
      wait_for_incoming_data <= nxt != IDLE;
      key_valid <= ev_key;
      ctrl_valid <= ev_ctrl;
      seq_error <= ev_err;
      if (ev_key) begin
        key_code <= d;
        key_ext <= ev_ext;
        key_break <= ev_brk;
        if (!ev_ext && d == JUMP_CODE) jump_held <= !ev_brk;
        if (ev_ext && d == DUCK_CODE) duck_held <= !ev_brk;
      end
      if (ev_ctrl) begin
        ctrl_byte <= d;
        if (d == 8'hAA) begin
          jump_held <= 1'b0;
          duck_held <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// tb_ps2_rx_sequencer: directed and random byte streams checked against a prefix-queue reference model
module tb_ps2_rx_sequencer;
  localparam int T = 16;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, tx_busy = 1'b0, rde = 1'b0;
  logic [7:0] rd = 8'h00;
  logic wait_for_incoming_data, start_receiving_data, key_ext, key_break, key_valid;
  logic ctrl_valid, jump_held, duck_held, seq_error;
  logic [7:0] key_code, ctrl_byte;
  int n_vec = 0, n_miss = 0;
  bit m_on, m_ext, m_brk, m_jump, m_duck, e_kv, e_cv, e_err;
  logic [7:0] m_code = 8'h00, m_ctrl = 8'h00;
  logic [7:0] pend[$];
  int idle = 0;
  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h29, 8'h72, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h1C, 8'h74, 8'h75};

  ps2_rx_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tx_busy(tx_busy),
    .received_data(rd), .received_data_en(rde),
    .wait_for_incoming_data(wait_for_incoming_data), .start_receiving_data(start_receiving_data),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid),
    .ctrl_byte(ctrl_byte), .ctrl_valid(ctrl_valid), .jump_held(jump_held), .duck_held(duck_held),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task key_ev(input logic [7:0] b, input bit e, input bit k);
    e_kv = 1'b1;
    m_code = b;
    m_ext = e;
    m_brk = k;
    if (!e && b == 8'h29) m_jump = !k;
    if (e && b == 8'h72) m_duck = !k;
  endtask

  // pend holds the prefix bytes seen since the last completed sequence
  task model(input bit v, input logic [7:0] b);
    bit c;
    c = b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
    e_kv = 1'b0;
    e_cv = 1'b0;
    e_err = 1'b0;
    if (!enable || tx_busy) begin
      m_on = 1'b0;
      pend.delete();
      idle = 0;
    end else if (!m_on) m_on = 1'b1;
    else if (v) begin
      idle = 0;
      if (pend.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
        else if (c) begin
          e_cv = 1'b1;
          m_ctrl = b;
          if (b == 8'hAA) begin
            m_jump = 1'b0;
            m_duck = 1'b0;
          end
        end else if (b == 8'hE1) e_err = 1'b1;
        else key_ev(b, 1'b0, 1'b0);
      end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
        if (b == 8'hF0) pend.push_back(b);
        else if (b != 8'hE0) begin
          if (c) e_err = 1'b1;
          else key_ev(b, 1'b1, 1'b0);
          pend.delete();
        end
      end else begin
        if (b == 8'hE0 || b == 8'hF0 || c) e_err = 1'b1;
        else key_ev(b, pend[0] == 8'hE0, 1'b1);
        pend.delete();
      end
    end
`ifdef PS2_RX_TIMEOUT_EN
    else if (pend.size() > 0) begin
      idle++;
      if (idle == T) begin
        e_err = 1'b1;
        pend.delete();
        idle = 0;
      end
    end
`endif
  endtask

  task step(input bit v, input logic [7:0] b);
    rde = v;
    rd = b;
    model(v, b);
    @(negedge clk);
    chk("key_valid", key_valid, e_kv);
    chk("ctrl_valid", ctrl_valid, e_cv);
    chk("seq_error", seq_error, e_err);
    chk("key_code", key_code, m_code);
    chk("key_ext", key_ext, m_ext);
    chk("key_break", key_break, m_brk);
    chk("ctrl_byte", ctrl_byte, m_ctrl);
    chk("jump_held", jump_held, m_jump);
    chk("duck_held", duck_held, m_duck);
    chk("wait_rx", wait_for_incoming_data, m_on);
    chk("start_rx", start_receiving_data, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    repeat (2) @(negedge clk);
    chk("rst_wait", wait_for_incoming_data, 1'b0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_ctrl", {ctrl_valid, ctrl_byte}, 9'h000);
    chk("rst_held", {jump_held, duck_held}, 2'b00);
    chk("rst_err", seq_error, 1'b0);
    reset = 1'b0;
    enable = 1'b1;
    step(1'b1, 8'h29);
    step(1'b0, 8'h00);
    step(1'b1, 8'h29);
    chk("t1_make", {key_valid, key_ext, key_break, key_code}, {3'b100, 8'h29});
    chk("t1_jump_set", jump_held, 1'b1);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h29);
    chk("t1_break", {key_valid, key_ext, key_break, key_code}, {3'b101, 8'h29});
    chk("t1_jump_clr", jump_held, 1'b0);
    step(1'b1, 8'hE0);
    step(1'b1, 8'h72);
    chk("t2_duck_set", {key_ext, duck_held}, 2'b11);
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h72);
    chk("t2_duck_clr", {key_ext, key_break, duck_held}, 3'b110);
    step(1'b1, 8'h72);
    step(1'b1, 8'h29);
    step(1'b1, 8'h29);
    step(1'b1, 8'hFA);
    step(1'b1, 8'hAA);
    chk("t3_aa", {ctrl_valid, ctrl_byte, jump_held}, {1'b1, 8'hAA, 1'b0});
    step(1'b1, 8'hF0);
    step(1'b1, 8'hF0);
    chk("t4_err", seq_error, 1'b1);
    step(1'b1, 8'h1C);
    step(1'b1, 8'hE1);
    step(1'b1, 8'hE0);
    tx_busy = 1'b1;
    step(1'b0, 8'h00);
    chk("t5_wait_drop", wait_for_incoming_data, 1'b0);
    step(1'b1, 8'h33);
    tx_busy = 1'b0;
    step(1'b0, 8'h00);
    step(1'b1, 8'h74);
    chk("t5_make", {key_valid, key_ext, key_code}, {2'b10, 8'h74});
    enable = 1'b0;
    step(1'b1, 8'h29);
    enable = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'hE0);
    repeat (20) step(1'b0, 8'h00);
    step(1'b1, 8'h75);
`ifdef PS2_RX_TIMEOUT_EN
    chk("t6_timeout_ext", key_ext, 1'b0);
`else
    chk("t6_wait_ext", key_ext, 1'b1);
`endif
    for (int i = 0; i < 800; i++) begin
      enable = $urandom_range(0, 19) != 0;
      tx_busy = $urandom_range(0, 19) == 0;
      b = $urandom_range(0, 3) == 0 ? 8'($urandom) : pool[$urandom_range(0, 11)];
      step(1'($urandom_range(0, 1)), b);
    end
    rde = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
